// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sequencer and its butterfly datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fft_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // FP16 complex sample as stored in the sample memory and consumed by full_butterfly.
    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } cplx_fp16_t;

    // Cycles from a read strobe to the matching butterfly result being ready to write.
    function automatic int pipe_lat(input int mem_rd_lat,
                                    input int butterfly_stages,
                                    input int mult_stages);
        return mem_rd_lat + butterfly_stages + mult_stages;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register used to align control/address fields with the datapath.
// Latency: DEPTH cycles from d to q (DEPTH >= 1).
// Backpressure: none; shifts every cycle, contents cleared by the async reset.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low clear of every stage
//   d          : WIDTH-bit input word
//   q          : d delayed by DEPTH cycles
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF FFT sequencer: per-stage read/twiddle/write address generation.
// Latency: read strobe 1 cycle after issue decision; bf_valid +MEM_RD_LAT; write +PIPE_LAT.
// Backpressure: i_hold stalls issue in RUN only; stalled cycles travel down as write bubbles.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_start              : start request (accepted in IDLE only)
//   i_hold               : skip issuing a butterfly this cycle (memory port conflict)
//   o_busy / o_done      : busy from RUN entry to DONE exit / one-cycle completion pulse
//   o_rd_en, o_rd_addr_* : operand read strobe and addresses for both memory ports
//   o_bf_valid, o_twiddle_addr : butterfly issue aligned with read data
//   o_wr_en, o_wr_addr_* : result write strobe and addresses aligned with butterfly outputs
//   o_stage              : current stage index
// Optional build macro FFT_SEQ_PERF_CNT_EN adds o_cycle_cnt and o_hold_cnt.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N            = 10,
    parameter int BUTTERFLY_STAGES = 2,
    parameter int MULT_STAGES      = 3,
    parameter int MEM_RD_LAT       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_hold,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rd_en,
    output logic [LOG2N-1:0]           o_rd_addr_top,
    output logic [LOG2N-1:0]           o_rd_addr_bot,
    output logic                       o_bf_valid,
    output logic [LOG2N-2:0]           o_twiddle_addr,
    output logic                       o_wr_en,
    output logic [LOG2N-1:0]           o_wr_addr_top,
    output logic [LOG2N-1:0]           o_wr_addr_bot,
    output logic [$clog2(LOG2N)-1:0]   o_stage
`ifdef FFT_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                o_cycle_cnt,
    output logic [31:0]                o_hold_cnt
`endif
);

    localparam int PIPE_LAT = pipe_lat(MEM_RD_LAT, BUTTERFLY_STAGES, MULT_STAGES);
    localparam int SW       = $clog2(LOG2N);
    localparam int KW       = LOG2N - 1;
    localparam int TW       = LOG2N - 1;
    localparam int DW       = $clog2(PIPE_LAT + 1);
    localparam int WR_W     = 1 + 2 * LOG2N;
    localparam int BF_W     = 1 + TW;

    localparam logic [KW-1:0]    K_LAST     = '1;
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(PIPE_LAT - 1);
    localparam logic [LOG2N-1:0] HALF_N     = {1'b1, {(LOG2N-1){1'b0}}};

    state_e          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [SW-1:0]   stage, stage_n;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic            issue;
    logic            done_set;
    logic [TW-1:0]   rd_tw;

    // ------------------------------------------------------------------
    // Address generation for butterfly k of the current stage.
    // span = N >> (stage+1) is a power of two, so the group offset
    // grp*2*span is just k with its low bits cleared, shifted left once,
    // and adding span to top never carries (top's span bit is zero).
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] k_ext, span, mask, j, ag_top, ag_bot;
    logic [TW-1:0]    ag_tw;

    always_comb begin
        k_ext  = {1'b0, k};
        span   = HALF_N >> stage;
        mask   = span - LOG2N'(1);
        j      = k_ext & mask;
        ag_top = ((k_ext & ~mask) << 1) | j;
        ag_bot = ag_top | span;
        // j < span <= N/2, so dropping j's MSB loses nothing before the shift.
        ag_tw  = j[TW-1:0] << stage;
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state and issue decision.
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        k_n      = k;
        stage_n  = stage;
        dcnt_n   = dcnt;
        issue    = 1'b0;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n = RUN;
                    k_n     = '0;
                    stage_n = '0;
                end
            end
            RUN: begin
                if (!i_hold) begin
                    issue = 1'b1;
                    if (k == K_LAST) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end else begin
                        k_n = k + KW'(1);
                    end
                end
            end
            DRAIN: begin
                // Wait out the full pipeline so the next stage never reads
                // a location whose update is still in flight.
                if (dcnt == DRAIN_LAST) begin
                    if (stage == STAGE_LAST) begin
                        state_n  = DONE;
                        done_set = 1'b1;
                    end else begin
                        state_n = RUN;
                        stage_n = stage + SW'(1);
                        k_n     = '0;
                    end
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            stage         <= '0;
            dcnt          <= '0;
            o_rd_en       <= 1'b0;
            o_rd_addr_top <= '0;
            o_rd_addr_bot <= '0;
            rd_tw         <= '0;
            o_done        <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            stage   <= stage_n;
            dcnt    <= dcnt_n;
            o_rd_en <= issue;
            if (issue) begin
                o_rd_addr_top <= ag_top;
                o_rd_addr_bot <= ag_bot;
                rd_tw         <= ag_tw;
            end
            o_done <= done_set;
            o_busy <= (state_n != IDLE);
        end
    end

    assign o_stage = stage;

    // ------------------------------------------------------------------
    // Alignment delay lines. Both are cleared by reset so an aborted run
    // cannot leave a stray write strobe behind.
    // ------------------------------------------------------------------
    logic [BF_W-1:0] bf_q;
    logic [WR_W-1:0] wr_q;

    fft_delay_line #(
        .WIDTH (BF_W),
        .DEPTH (MEM_RD_LAT)
    ) u_bf_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({o_rd_en, rd_tw}),
        .q     (bf_q)
    );

    fft_delay_line #(
        .WIDTH (WR_W),
        .DEPTH (PIPE_LAT)
    ) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({o_rd_en, o_rd_addr_top, o_rd_addr_bot}),
        .q     (wr_q)
    );

    assign {o_bf_valid, o_twiddle_addr}           = bf_q;
    assign {o_wr_en, o_wr_addr_top, o_wr_addr_bot} = wr_q;

`ifdef FFT_SEQ_PERF_CNT_EN
    // Cycle count covers RUN and DRAIN, so it reads the start-to-done
    // distance when o_done is high; both counters freeze outside a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cycle_cnt <= '0;
            o_hold_cnt  <= '0;
        end else if (state == IDLE && i_start) begin
            o_cycle_cnt <= '0;
            o_hold_cnt  <= '0;
        end else begin
            if (state == RUN || state == DRAIN) begin
                o_cycle_cnt <= o_cycle_cnt + 32'd1;
            end
            if (state == RUN && i_hold) begin
                o_hold_cnt <= o_hold_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at LOG2N=3.
// Expected read/bf/write event timelines come from an array model of the stage rules.
// Covers reset, no-hold, fixed hold, random holds, ignored restarts and mid-run reset.
module tb_fft_stage_sequencer;

    localparam int LOG2N            = 3;
    localparam int N                = 1 << LOG2N;
    localparam int HALF             = N / 2;
    localparam int MEM_RD_LAT       = 1;
    localparam int BUTTERFLY_STAGES = 2;
    localparam int MULT_STAGES      = 3;
    localparam int PIPE             = MEM_RD_LAT + BUTTERFLY_STAGES + MULT_STAGES;
    localparam int MAXE             = 256;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_hold = 1'b0;
    logic               o_busy, o_done, o_rd_en, o_bf_valid, o_wr_en;
    logic [LOG2N-1:0]   o_rd_addr_top, o_rd_addr_bot, o_wr_addr_top, o_wr_addr_bot;
    logic [LOG2N-2:0]   o_twiddle_addr;
    logic [$clog2(LOG2N)-1:0] o_stage;
`ifdef FFT_SEQ_PERF_CNT_EN
    logic [31:0]        o_cycle_cnt, o_hold_cnt;
`endif

    fft_stage_sequencer #(
        .LOG2N            (LOG2N),
        .BUTTERFLY_STAGES (BUTTERFLY_STAGES),
        .MULT_STAGES      (MULT_STAGES),
        .MEM_RD_LAT       (MEM_RD_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_hold         (i_hold),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_rd_en        (o_rd_en),
        .o_rd_addr_top  (o_rd_addr_top),
        .o_rd_addr_bot  (o_rd_addr_bot),
        .o_bf_valid     (o_bf_valid),
        .o_twiddle_addr (o_twiddle_addr),
        .o_wr_en        (o_wr_en),
        .o_wr_addr_top  (o_wr_addr_top),
        .o_wr_addr_bot  (o_wr_addr_bot),
        .o_stage        (o_stage)
`ifdef FFT_SEQ_PERF_CNT_EN
        ,
        .o_cycle_cnt    (o_cycle_cnt),
        .o_hold_cnt     (o_hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int top;
        int bot;
        int tw;
        int stage;
    } ev_t;

    ev_t exp_rd[$];
    ev_t obs_rd[$];
    ev_t obs_bf[$];
    ev_t obs_wr[$];
    bit  hold_pat[MAXE];
    bit  start_pat[MAXE];
    int  exp_done, exp_holds;
    int  obs_done, obs_done_cnt, obs_cyc, obs_hold;
    logic obs_busy_at_done;
    int  total = 0;
    int  bad = 0;

    task automatic clear_pats();
        for (int e = 0; e < MAXE; e++) begin
            hold_pat[e]  = 1'b0;
            start_pat[e] = 1'b0;
        end
        start_pat[0] = 1'b1;
    endtask

    // Edge 0 accepts start; butterflies are issued in order on the first
    // non-held edges of each stage, every stage followed by PIPE drain edges.
    task automatic build_model();
        int cur, last_e, span, j, grp, top;
        exp_rd.delete();
        exp_holds = 0;
        cur       = 1;
        last_e    = 0;
        for (int s = 0; s < LOG2N; s++) begin
            span = N >> (s + 1);
            for (int k = 0; k < HALF; k++) begin
                while (cur < MAXE && hold_pat[cur]) begin
                    exp_holds++;
                    cur++;
                end
                j   = k % span;
                grp = k / span;
                top = grp * 2 * span + j;
                exp_rd.push_back('{cur, top, top + span, (j * (1 << s)) % HALF, s});
                last_e = cur;
                cur++;
            end
            cur = last_e + PIPE + 1;
        end
        exp_done = last_e + PIPE;
    endtask

    task automatic run_seq();
        obs_rd.delete();
        obs_bf.delete();
        obs_wr.delete();
        obs_done         = -1;
        obs_done_cnt     = 0;
        obs_cyc          = -1;
        obs_hold         = -1;
        obs_busy_at_done = 1'b0;
        for (int e = 0; e < MAXE; e++) begin
            i_hold  = hold_pat[e];
            i_start = start_pat[e];
            @(posedge clk);
            #1;
            if (o_rd_en === 1'b1)
                obs_rd.push_back('{e, int'(o_rd_addr_top), int'(o_rd_addr_bot), 0, int'(o_stage)});
            if (o_bf_valid === 1'b1)
                obs_bf.push_back('{e, 0, 0, int'(o_twiddle_addr), 0});
            if (o_wr_en === 1'b1)
                obs_wr.push_back('{e, int'(o_wr_addr_top), int'(o_wr_addr_bot), 0, 0});
            if (o_done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done < 0) begin
                    obs_done         = e;
                    obs_busy_at_done = o_busy;
`ifdef FFT_SEQ_PERF_CNT_EN
                    obs_cyc  = int'(o_cycle_cnt);
                    obs_hold = int'(o_hold_cnt);
`endif
                end
            end
            if (obs_done >= 0 && e >= obs_done + 3) break;
        end
        i_hold  = 1'b0;
        i_start = 1'b0;
    endtask

    // Scenario runner: model the current patterns, drive them, compare timelines.
    task automatic test_sequence(input string name);
        int n;
        build_model();
        run_seq();
        total++;
        if (obs_done !== exp_done) begin
            bad++;
            $display("FAIL %s done_edge got=%0d want=%0d", name, obs_done, exp_done);
        end
        total++;
        if (obs_done_cnt !== 1) begin
            bad++;
            $display("FAIL %s done_pulses got=%0d want=1", name, obs_done_cnt);
        end
        total++;
        if (obs_busy_at_done !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy at_done=%b after=%b want 1/0", name, obs_busy_at_done, o_busy);
        end
        total++;
        if (obs_rd.size() != exp_rd.size() || obs_bf.size() != exp_rd.size() ||
            obs_wr.size() != exp_rd.size()) begin
            bad++;
            $display("FAIL %s event_counts rd=%0d bf=%0d wr=%0d want=%0d", name,
                     obs_rd.size(), obs_bf.size(), obs_wr.size(), exp_rd.size());
        end
        n = exp_rd.size();
        if (obs_rd.size() < n) n = obs_rd.size();
        if (obs_bf.size() < n) n = obs_bf.size();
        if (obs_wr.size() < n) n = obs_wr.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (obs_rd[i].e !== exp_rd[i].e || obs_rd[i].top !== exp_rd[i].top ||
                obs_rd[i].bot !== exp_rd[i].bot || obs_rd[i].stage !== exp_rd[i].stage) begin
                bad++;
                $display("FAIL %s rd[%0d] got e=%0d top=%0d bot=%0d st=%0d want e=%0d top=%0d bot=%0d st=%0d",
                         name, i, obs_rd[i].e, obs_rd[i].top, obs_rd[i].bot, obs_rd[i].stage,
                         exp_rd[i].e, exp_rd[i].top, exp_rd[i].bot, exp_rd[i].stage);
            end
            total++;
            if (obs_bf[i].e !== exp_rd[i].e + MEM_RD_LAT || obs_bf[i].tw !== exp_rd[i].tw) begin
                bad++;
                $display("FAIL %s bf[%0d] got e=%0d tw=%0d want e=%0d tw=%0d", name, i,
                         obs_bf[i].e, obs_bf[i].tw, exp_rd[i].e + MEM_RD_LAT, exp_rd[i].tw);
            end
            total++;
            if (obs_wr[i].e !== exp_rd[i].e + PIPE || obs_wr[i].top !== exp_rd[i].top ||
                obs_wr[i].bot !== exp_rd[i].bot) begin
                bad++;
                $display("FAIL %s wr[%0d] got e=%0d top=%0d bot=%0d want e=%0d top=%0d bot=%0d",
                         name, i, obs_wr[i].e, obs_wr[i].top, obs_wr[i].bot,
                         exp_rd[i].e + PIPE, exp_rd[i].top, exp_rd[i].bot);
            end
        end
`ifdef FFT_SEQ_PERF_CNT_EN
        total++;
        if (obs_cyc !== exp_done || obs_hold !== exp_holds) begin
            bad++;
            $display("FAIL %s perf got cyc=%0d hold=%0d want cyc=%0d hold=%0d", name,
                     obs_cyc, obs_hold, exp_done, exp_holds);
        end
        total++;
        if (int'(o_cycle_cnt) !== exp_done || int'(o_hold_cnt) !== exp_holds) begin
            bad++;
            $display("FAIL %s perf_idle got cyc=%0d hold=%0d want cyc=%0d hold=%0d", name,
                     o_cycle_cnt, o_hold_cnt, exp_done, exp_holds);
        end
`endif
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({o_busy, o_done, o_rd_en, o_bf_valid, o_wr_en} !== 5'b0 ||
            o_rd_addr_top !== '0 || o_rd_addr_bot !== '0 || o_twiddle_addr !== '0 ||
            o_wr_addr_top !== '0 || o_wr_addr_bot !== '0 || o_stage !== '0) begin
            bad++;
            $display("FAIL %s outputs busy=%b done=%b rd=%b bf=%b wr=%b rt=%0d rb=%0d tw=%0d wt=%0d wb=%0d st=%0d want all 0",
                     name, o_busy, o_done, o_rd_en, o_bf_valid, o_wr_en, o_rd_addr_top,
                     o_rd_addr_bot, o_twiddle_addr, o_wr_addr_top, o_wr_addr_bot, o_stage);
        end
`ifdef FFT_SEQ_PERF_CNT_EN
        total++;
        if (o_cycle_cnt !== 32'd0 || o_hold_cnt !== 32'd0) begin
            bad++;
            $display("FAIL %s perf got cyc=%0d hold=%0d want 0/0", name, o_cycle_cnt, o_hold_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_idle");
    endtask

    task automatic test_no_hold();
        clear_pats();
        test_sequence("no_hold");
        total++;
        if (obs_done !== LOG2N * (HALF + PIPE)) begin
            bad++;
            $display("FAIL no_hold total_cycles got=%0d want=%0d", obs_done, LOG2N * (HALF + PIPE));
        end
    endtask

    task automatic test_hold_mid();
        clear_pats();
        // Stage 1 issues from edge 11; hold its second butterfly for three edges.
        hold_pat[12] = 1'b1;
        hold_pat[13] = 1'b1;
        hold_pat[14] = 1'b1;
        test_sequence("hold_mid");
        total++;
        if (obs_done !== 33) begin
            bad++;
            $display("FAIL hold_mid done_edge got=%0d want=33", obs_done);
        end
    endtask

    task automatic test_start_ignored();
        clear_pats();
        start_pat[5]  = 1'b1;
        start_pat[13] = 1'b1;
        start_pat[25] = 1'b1;
        start_pat[30] = 1'b1;
        test_sequence("start_ignored");
    endtask

    task automatic test_random_hold();
        for (int r = 0; r < 6; r++) begin
            clear_pats();
            for (int e = 1; e < 100; e++) begin
                hold_pat[e] = ($urandom_range(0, 3) == 0);
            end
            test_sequence($sformatf("random_hold%0d", r));
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        clear_pats();
        // Run into stage 1 DRAIN (edges 15..20) while its writes are in flight.
        for (int e = 0; e <= 17; e++) begin
            i_start = start_pat[e];
            i_hold  = 1'b0;
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        total++;
        if (o_wr_en !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre_reset wr=%b busy=%b want 1/1", o_wr_en, o_busy);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (o_wr_en !== 1'b0 || o_rd_en !== 1'b0 || o_busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_mid stray_activity got=%0d want=0", stray);
        end
        test_sequence("restart_after_reset");
    endtask

    initial begin
        test_reset();
        test_no_hold();
        test_hold_mid();
        test_start_ignored();
        test_random_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
